key_conditioner: RTL and testbench
==================================

Name: key_conditioner

Overview:
- Conditions the raw board inputs (eight note slide switches, MODE pushbutton) before they reach the piano core.
- Synchronises and debounces every input, then presents clean switch levels to the core.
- Also provides a priority-encoded note index with note-on/note-off event pulses, and a debounced mode toggle.
- Sits directly upstream of the piano block; its sw_clean output drives the core's sw input.

Parameters:
- DEBOUNCE_CYCLES, 50000, consecutive CLK cycles a synchronised input must differ from its clean value before the clean value updates (legal range 2..2^CNT_W-1).
- CNT_W, 16, width of each per-input debounce counter.

Ports:
- CLK  in  1  system clock.
- RESET  in  1  reset, asynchronous, active-low.
- sw_raw  in  8  raw slide switches; bit7=C4, bit6=D, bit5=E, bit4=F, bit3=G, bit2=A, bit1=B, bit0=C5.
- mode_raw  in  1  raw MODE pushbutton, active-high.
- sw_clean  out  8  debounced switch levels.
- note_valid  out  1  high while any sw_clean bit is set.
- note_idx  out  3  bit position of the highest set sw_clean bit.
- note_on  out  1  one-cycle pulse when a new note becomes active.
- note_off  out  1  one-cycle pulse when the last note is released.
- mode_toggle  out  1  one-cycle pulse on each debounced MODE press.
- mode_state  out  1  toggles on every debounced MODE press.

Behaviour:
- Reset (RESET low, asynchronous): all synchroniser flops, counters, sw_clean, mode_clean, note_idx, note_valid, note_on, note_off, mode_toggle and mode_state go to 0. Outputs stay 0 until RESET is high and a full debounce interval has completed.
- Synchronisation: each of the 9 inputs passes through a 2-flop synchroniser. s2 is the second stage.
- Debounce, per input, independent of the others:
  - On a CLK edge where s2 != clean, the counter increments.
  - On the edge where the counter would reach DEBOUNCE_CYCLES, clean <= s2 and the counter clears.
  - On an edge where s2 == clean, the counter clears.
  - Any glitch shorter than DEBOUNCE_CYCLES cycles at s2 is rejected.
  - Counter saturation is impossible given the parameter range.
- Latency: a raw change present before edge 1 reaches s2 at edge 2 and sw_clean at edge 2+DEBOUNCE_CYCLES. Encoder outputs follow one edge later (3+DEBOUNCE_CYCLES).
- Encoder (all outputs registered, computed from sw_clean):
  - note_valid = OR of sw_clean.
  - note_idx = index of the highest set bit, so the lowest pitch wins (bit7 over bit0). note_idx holds its last value while note_valid = 0.
  - note_on pulses when note_valid rises, or when note_valid stays 1 and note_idx changes. No note_off is generated on a note-to-note change.
  - note_off pulses when note_valid falls.
  - note_on and note_off are never high in the same cycle.
  - Releasing a lower-priority bit while a higher-priority bit stays held produces no pulse.
- Mode:
  - mode_toggle pulses for one cycle on a 0->1 transition of debounced mode_clean. mode_state flips in the same edge.
  - Release (1->0) produces no pulse.
  - Holding the button produces exactly one toggle.
- Simultaneous events: several switches settling on the same edge are encoded together, giving one note_on with the final priority index. A mode press coinciding with a note change is handled independently.
- Reset mid-debounce: counters clear and the pending change is discarded. After reset release, a stable input is re-qualified from zero.

Test Plan:
All scenarios use DEBOUNCE_CYCLES=4.
- Reset-release with sw_raw=0 -> all outputs 0. Then set sw_raw=8'h20 before edge 1 -> sw_clean=8'h20 at edge 6; note_valid=1, note_idx=5, note_on pulse at edge 7.
- sw_raw[3] high for 3 cycles then low -> sw_clean, note_on and note_valid never change.
- Hold bit5, then add bit7 -> note_on pulse with note_idx=7. Drop bit7 -> note_on with note_idx=5 and no note_off. Drop bit5 -> single note_off, note_idx stays 5.
- sw_raw changes 8'h00->8'h18 in one cycle -> one note_on, note_idx=4.
- mode_raw held high 20 cycles -> exactly one mode_toggle, mode_state 0->1. Second press -> mode_state 1->0. Bouncing press (1,0,1,0 per cycle, then stable 1) -> one toggle.
- Assert RESET low two cycles into a sw_raw[6] qualification -> outputs 0 immediately. After release with sw_raw[6] still high, sw_clean[6] sets 6 edges after release.

Source files
------------

// File: rtl/key_conditioner.sv
// rtl/key_conditioner.sv - input synchroniser, debouncer, note encoder and mode toggle
module key_conditioner #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_W           = 16
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [7:0] sw_raw,
    input  logic       mode_raw,
    output logic [7:0] sw_clean,
    output logic       note_valid,
    output logic [2:0] note_idx,
    output logic       note_on,
    output logic       note_off,
    output logic       mode_toggle,
    output logic       mode_state
);

    // Bits 7:0 are the note switches, bit 8 is the MODE button; all nine
    // share the same synchroniser and debounce treatment.
    localparam int N = 9;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [N-1:0]     raw_all;
    logic [N-1:0]     s1;
    logic [N-1:0]     s2;
    logic [N-1:0]     clean;
    logic [CNT_W-1:0] cnt [N];
    logic             mode_clean;
    logic             mode_d;
    logic             any_set;
    logic [2:0]       hi_idx;
    logic             mode_rise;

    assign raw_all    = {mode_raw, sw_raw};
    assign sw_clean   = clean[7:0];
    assign mode_clean = clean[8];

    // Two-flop synchroniser for every raw input.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= raw_all;
            s2 <= s1;
        end
    end

    // Per-input debounce: the clean level only follows s2 after it has
    // disagreed for DEBOUNCE_CYCLES consecutive edges; any agreement restarts.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            clean <= '0;
            for (int i = 0; i < N; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                if (s2[i] != clean[i]) begin
                    if (cnt[i] == CNT_LAST) begin
                        clean[i] <= s2[i];
                        cnt[i]   <= '0;
                    end else begin
                        cnt[i] <= cnt[i] + 1'b1;
                    end
                end else begin
                    cnt[i] <= '0;
                end
            end
        end
    end

    // Priority encoder: ascending scan so the highest set bit (lowest pitch) wins.
    always_comb begin
        any_set = |clean[7:0];
        hi_idx  = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (clean[i]) begin
                hi_idx = 3'(i);
            end
        end
    end

    // Registered note outputs; note_idx is held while no switch is active so
    // the core still sees the last note during its release.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            note_valid <= 1'b0;
            note_idx   <= 3'd0;
            note_on    <= 1'b0;
            note_off   <= 1'b0;
        end else begin
            note_valid <= any_set;
            note_on    <= any_set && (!note_valid || (hi_idx != note_idx));
            note_off   <= !any_set && note_valid;
            if (any_set) begin
                note_idx <= hi_idx;
            end
        end
    end

    assign mode_rise = mode_clean && !mode_d;

    // Press-only edge detect on the debounced MODE level; release is ignored.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            mode_d      <= 1'b0;
            mode_toggle <= 1'b0;
            mode_state  <= 1'b0;
        end else begin
            mode_d      <= mode_clean;
            mode_toggle <= mode_rise;
            mode_state  <= mode_state ^ mode_rise;
        end
    end

endmodule

// File: tb/tb_key_conditioner.sv
// tb/tb_key_conditioner.sv - randomized bench for key_conditioner against a windowed reference model
module tb_key_conditioner;

    localparam int D = 4;

    logic       CLK = 1'b0;
    logic       RESET = 1'b0;
    logic [7:0] sw_raw = 8'h00;
    logic       mode_raw = 1'b0;
    logic [7:0] sw_clean;
    logic       note_valid;
    logic [2:0] note_idx;
    logic       note_on;
    logic       note_off;
    logic       mode_toggle;
    logic       mode_state;

    key_conditioner #(.DEBOUNCE_CYCLES(D), .CNT_W(16)) dut (
        .CLK(CLK), .RESET(RESET), .sw_raw(sw_raw), .mode_raw(mode_raw),
        .sw_clean(sw_clean), .note_valid(note_valid), .note_idx(note_idx),
        .note_on(note_on), .note_off(note_off),
        .mode_toggle(mode_toggle), .mode_state(mode_state)
    );

    always #5 CLK = ~CLK;

    int n_chk = 0;
    int n_pass = 0;
    int on_cnt, off_cnt, tog_cnt;

    // reference model state
    logic [8:0] m_s1, m_s2, m_clean;
    logic [8:0] hist [$];
    logic       e_valid, e_on, e_off, e_tog, e_state, m_mprev;
    logic [2:0] e_idx;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    function automatic logic [2:0] highest(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) if (v[i]) return 3'(i);
        return 3'd0;
    endfunction

    task automatic model_reset();
        m_s1 = '0; m_s2 = '0; m_clean = '0; hist.delete();
        e_valid = 0; e_on = 0; e_off = 0; e_tog = 0; e_state = 0; m_mprev = 0; e_idx = 0;
    endtask

    // One clock edge: the clean level flips once the last D synchronised
    // samples all disagree with it; encoder/mode outputs lag clean by one edge.
    task automatic model_edge(input logic [8:0] raw9);
        logic [8:0] old;
        logic [8:0] dropped;
        logic       all_diff;
        logic       nz;
        logic [2:0] hi;
        old = m_clean;
        hist.push_back(m_s2);
        if (hist.size() > D) dropped = hist.pop_front();
        for (int b = 0; b < 9; b++) begin
            if (hist.size() == D) begin
                all_diff = 1'b1;
                for (int k = 0; k < D; k++) if (hist[k][b] == old[b]) all_diff = 1'b0;
                if (all_diff) m_clean[b] = ~old[b];
            end
        end
        nz = (old[7:0] != 8'h00);
        hi = highest(old[7:0]);
        e_on  = nz && (!e_valid || hi != e_idx);
        e_off = !nz && e_valid;
        if (nz) e_idx = hi;
        e_valid = nz;
        e_tog = old[8] && !m_mprev;
        m_mprev = old[8];
        e_state = e_state ^ e_tog;
        m_s2 = m_s1;
        m_s1 = raw9;
    endtask

    task automatic compare_all();
        chk("sw_clean", 32'(sw_clean), 32'(m_clean[7:0]));
        chk("note_valid", 32'(note_valid), 32'(e_valid));
        chk("note_idx", 32'(note_idx), 32'(e_idx));
        chk("note_on", 32'(note_on), 32'(e_on));
        chk("note_off", 32'(note_off), 32'(e_off));
        chk("mode_toggle", 32'(mode_toggle), 32'(e_tog));
        chk("mode_state", 32'(mode_state), 32'(e_state));
        chk("on_off_excl", 32'(note_on & note_off), 32'd0);
    endtask

    task automatic step(input logic [7:0] sw, input logic m);
        @(negedge CLK);
        compare_all();
        on_cnt  += int'(note_on);
        off_cnt += int'(note_off);
        tog_cnt += int'(mode_toggle);
        sw_raw = sw;
        mode_raw = m;
        @(posedge CLK);
        model_edge({m, sw});
    endtask

    task automatic run(input logic [7:0] sw, input logic m, input int n);
        for (int i = 0; i < n; i++) step(sw, m);
    endtask

    task automatic clr_counts();
        on_cnt = 0; off_cnt = 0; tog_cnt = 0;
    endtask

    // Asynchronous reset asserted mid-cycle, released just after a rising edge
    // so the next model step sees the first post-release edge.
    task automatic do_reset();
        @(negedge CLK);
        compare_all();
        #2 RESET = 1'b0;
        #1;
        chk("rst_sw_clean", 32'(sw_clean), 32'd0);
        chk("rst_note_idx", 32'(note_idx), 32'd0);
        chk("rst_mode_state", 32'(mode_state), 32'd0);
        chk("rst_note_valid", 32'(note_valid), 32'd0);
        model_reset();
        @(posedge CLK);
        @(posedge CLK);
        #1 RESET = 1'b1;
    endtask

    initial begin
        model_reset();
        clr_counts();
        repeat (2) @(posedge CLK);
        #1 RESET = 1'b1;

        // reset state and first qualification latency
        run(8'h00, 1'b0, 6);
        run(8'h20, 1'b0, 5);
        #1 chk("e5_sw_clean", 32'(sw_clean), 32'h00);
        run(8'h20, 1'b0, 1);
        #1 chk("e6_sw_clean", 32'(sw_clean), 32'h20);
        chk("e6_note_valid", 32'(note_valid), 32'd0);
        run(8'h20, 1'b0, 1);
        #1 chk("e7_note_on", 32'(note_on), 32'd1);
        chk("e7_note_idx", 32'(note_idx), 32'd5);
        run(8'h20, 1'b0, 6);

        // short glitch on bit3 is rejected
        clr_counts();
        run(8'h28, 1'b0, 3);
        run(8'h20, 1'b0, 12);
        chk("glitch_on", 32'(on_cnt), 32'd0);
        chk("glitch_clean", 32'(sw_clean), 32'h20);

        // priority changes
        clr_counts();
        run(8'hA0, 1'b0, 12);
        chk("add7_on", 32'(on_cnt), 32'd1);
        chk("add7_idx", 32'(note_idx), 32'd7);
        clr_counts();
        run(8'h20, 1'b0, 12);
        chk("drop7_on", 32'(on_cnt), 32'd1);
        chk("drop7_off", 32'(off_cnt), 32'd0);
        chk("drop7_idx", 32'(note_idx), 32'd5);
        clr_counts();
        run(8'h00, 1'b0, 12);
        chk("drop5_off", 32'(off_cnt), 32'd1);
        chk("drop5_on", 32'(on_cnt), 32'd0);
        chk("drop5_idx", 32'(note_idx), 32'd5);

        // simultaneous settle
        clr_counts();
        run(8'h18, 1'b0, 12);
        chk("simul_on", 32'(on_cnt), 32'd1);
        chk("simul_idx", 32'(note_idx), 32'd4);
        run(8'h00, 1'b0, 12);

        // mode button: hold, second press, bouncing press
        clr_counts();
        run(8'h00, 1'b1, 20);
        chk("hold_tog", 32'(tog_cnt), 32'd1);
        chk("hold_state", 32'(mode_state), 32'd1);
        run(8'h00, 1'b0, 12);
        clr_counts();
        run(8'h00, 1'b1, 12);
        run(8'h00, 1'b0, 12);
        chk("press2_tog", 32'(tog_cnt), 32'd1);
        chk("press2_state", 32'(mode_state), 32'd0);
        clr_counts();
        step(8'h00, 1'b1); step(8'h00, 1'b0); step(8'h00, 1'b1); step(8'h00, 1'b0);
        run(8'h00, 1'b1, 12);
        chk("bounce_tog", 32'(tog_cnt), 32'd1);
        chk("bounce_state", 32'(mode_state), 32'd1);

        // reset in the middle of a bit6 qualification
        run(8'h40, 1'b1, 2);
        sw_raw = 8'h40;
        mode_raw = 1'b0;
        do_reset();
        run(8'h40, 1'b0, 5);
        #1 chk("rst_e5_clean", 32'(sw_clean), 32'h00);
        run(8'h40, 1'b0, 1);
        #1 chk("rst_e6_clean", 32'(sw_clean), 32'h40);
        run(8'h40, 1'b0, 4);

        // randomized segments of varying hold length
        for (int seg = 0; seg < 80; seg++) begin
            logic [7:0] sw;
            logic       m;
            int         len;
            sw  = 8'($urandom);
            if ($urandom_range(0, 2) == 0) sw = sw & 8'($urandom);
            m   = 1'($urandom_range(0, 1));
            len = $urandom_range(1, 9);
            if (seg == 40) begin
                sw_raw = sw;
                mode_raw = m;
                do_reset();
            end
            run(sw, m, len);
        end
        run(8'h00, 1'b0, 12);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
